// File: rtl/ex_operand_stage.sv
// ex_operand_stage
//   Single-entry ID/EX buffer feeding the execute-stage ALU. Holds one decoded
//   instruction under a valid/ready handshake. Operands are forwarded from the
//   MEM and WB stages combinationally. out_valid is withheld on a load-use
//   hazard.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   in_valid / in_ready         decode-side handshake
//   in_*                        decoded instruction fields to capture
//   flush                       kill the held instruction (branch redirect)
//   mem_* / wb_*                producer results for forwarding / hazard detection
//   out_valid / out_ready       execute-side handshake
//   A, B, Ctr                   ALU operands and control code
//   out_rs2_fwd                 forwarded rs2 value (store data)
//   out_pc, out_rd_addr, out_rd_we  held fields passed through
//   stall_cnt                   saturating count of load-use stall cycles
module ex_operand_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [RA_W-1:0] in_rs1_addr,
  input  logic [RA_W-1:0] in_rs2_addr,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_a_sel_pc,
  input  logic            in_b_sel_imm,
  input  logic [3:0]      in_ctr,
  input  logic [RA_W-1:0] in_rd_addr,
  input  logic            in_rd_we,
  input  logic            flush,
  input  logic [RA_W-1:0] mem_rd_addr,
  input  logic            mem_rd_we,
  input  logic            mem_is_load,
  input  logic [XLEN-1:0] mem_data,
  input  logic [RA_W-1:0] wb_rd_addr,
  input  logic            wb_rd_we,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] A,
  output logic [XLEN-1:0] B,
  output logic [3:0]      Ctr,
  output logic [XLEN-1:0] out_rs2_fwd,
  output logic [XLEN-1:0] out_pc,
  output logic [RA_W-1:0] out_rd_addr,
  output logic            out_rd_we,
  output logic [15:0]     stall_cnt
);

  logic            full_q,      full_d;
  logic [XLEN-1:0] pc_q,        pc_d;
  logic [RA_W-1:0] rs1_addr_q,  rs1_addr_d;
  logic [RA_W-1:0] rs2_addr_q,  rs2_addr_d;
  logic [XLEN-1:0] rs1_data_q,  rs1_data_d;
  logic [XLEN-1:0] rs2_data_q,  rs2_data_d;
  logic [XLEN-1:0] imm_q,       imm_d;
  logic            a_sel_pc_q,  a_sel_pc_d;
  logic            b_sel_imm_q, b_sel_imm_d;
  logic [3:0]      ctr_q,       ctr_d;
  logic [RA_W-1:0] rd_addr_q,   rd_addr_d;
  logic            rd_we_q,     rd_we_d;
  logic [15:0]     stall_cnt_q, stall_cnt_d;

  logic            in_fire, out_fire, hazard;
  logic            haz_rs1, haz_rs2;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // MEM has priority over WB; a load in MEM has no data yet so it never
  // forwards (that case is a hazard instead). x0 never forwards.
  function automatic logic [XLEN-1:0] forward(input logic [RA_W-1:0] rs,
                                              input logic [XLEN-1:0] held);
    logic [XLEN-1:0] r;
    r = held;
    if (rs != '0) begin
      if (mem_rd_we && !mem_is_load && mem_rd_addr == rs)
        r = mem_data;
      else if (wb_rd_we && wb_rd_addr == rs)
        r = wb_data;
    end
    return r;
  endfunction

  function automatic logic load_hit(input logic [RA_W-1:0] rs);
    return mem_rd_we && mem_is_load && (rs != '0) && (mem_rd_addr == rs);
  endfunction

  always_comb begin
    fwd_rs1 = forward(rs1_addr_q, rs1_data_q);
    fwd_rs2 = forward(rs2_addr_q, rs2_data_q);
    // rs1 is irrelevant when A takes the PC; rs2 always matters (store data).
    haz_rs1 = !a_sel_pc_q && load_hit(rs1_addr_q);
    haz_rs2 = load_hit(rs2_addr_q);
    hazard  = full_q && (haz_rs1 || haz_rs2);

    out_valid = full_q && !hazard;
    out_fire  = out_valid && out_ready;
    in_ready  = !full_q || out_fire;
    in_fire   = in_valid && in_ready;

    A           = a_sel_pc_q  ? pc_q  : fwd_rs1;
    B           = b_sel_imm_q ? imm_q : fwd_rs2;
    Ctr         = ctr_q;
    out_rs2_fwd = fwd_rs2;
    out_pc      = pc_q;
    out_rd_addr = rd_addr_q;
    out_rd_we   = rd_we_q;
    stall_cnt   = stall_cnt_q;
  end

  always_comb begin
    full_d      = full_q;
    pc_d        = pc_q;
    rs1_addr_d  = rs1_addr_q;
    rs2_addr_d  = rs2_addr_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    a_sel_pc_d  = a_sel_pc_q;
    b_sel_imm_d = b_sel_imm_q;
    ctr_d       = ctr_q;
    rd_addr_d   = rd_addr_q;
    rd_we_d     = rd_we_q;
    stall_cnt_d = hazard ? sat_inc16(stall_cnt_q) : stall_cnt_q;

    // Flush wins over a same-cycle accept: the incoming instruction is dropped.
    if (flush) begin
      full_d = 1'b0;
    end else if (in_fire) begin
      full_d      = 1'b1;
      pc_d        = in_pc;
      rs1_addr_d  = in_rs1_addr;
      rs2_addr_d  = in_rs2_addr;
      rs1_data_d  = in_rs1_data;
      rs2_data_d  = in_rs2_data;
      imm_d       = in_imm;
      a_sel_pc_d  = in_a_sel_pc;
      b_sel_imm_d = in_b_sel_imm;
      ctr_d       = in_ctr;
      rd_addr_d   = in_rd_addr;
      rd_we_d     = in_rd_we;
    end else if (out_fire) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q      <= 1'b0;
      pc_q        <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      a_sel_pc_q  <= 1'b0;
      b_sel_imm_q <= 1'b0;
      ctr_q       <= '0;
      rd_addr_q   <= '0;
      rd_we_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      full_q      <= full_d;
      pc_q        <= pc_d;
      rs1_addr_q  <= rs1_addr_d;
      rs2_addr_q  <= rs2_addr_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      a_sel_pc_q  <= a_sel_pc_d;
      b_sel_imm_q <= b_sel_imm_d;
      ctr_q       <= ctr_d;
      rd_addr_q   <= rd_addr_d;
      rd_we_q     <= rd_we_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;
  localparam int XLEN = 32;
  localparam int RA_W = 5;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [31:0] d1;
    logic [4:0]  rs2;
    logic [31:0] d2;
    logic [31:0] imm;
    logic        asel;
    logic        bsel;
    logic [3:0]  ctr;
    logic [4:0]  rd;
    logic        we;
  } instr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, in_valid, in_ready, flush;
  logic [RA_W-1:0] mem_rd_addr, wb_rd_addr, out_rd_addr;
  logic            mem_rd_we, mem_is_load, wb_rd_we;
  logic [XLEN-1:0] mem_data, wb_data;
  logic            out_valid, out_ready, out_rd_we;
  logic [XLEN-1:0] A, B, out_rs2_fwd, out_pc;
  logic [3:0]      Ctr;
  logic [15:0]     stall_cnt;
  instr_t          nxt;

  ex_operand_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(nxt.pc), .in_rs1_addr(nxt.rs1), .in_rs2_addr(nxt.rs2),
    .in_rs1_data(nxt.d1), .in_rs2_data(nxt.d2), .in_imm(nxt.imm),
    .in_a_sel_pc(nxt.asel), .in_b_sel_imm(nxt.bsel), .in_ctr(nxt.ctr),
    .in_rd_addr(nxt.rd), .in_rd_we(nxt.we), .flush(flush),
    .mem_rd_addr(mem_rd_addr), .mem_rd_we(mem_rd_we), .mem_is_load(mem_is_load),
    .mem_data(mem_data), .wb_rd_addr(wb_rd_addr), .wb_rd_we(wb_rd_we),
    .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
    .A(A), .B(B), .Ctr(Ctr), .out_rs2_fwd(out_rs2_fwd), .out_pc(out_pc),
    .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we), .stall_cnt(stall_cnt)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  instr_t      m_h;
  bit          m_full = 1'b0;
  int unsigned m_stall = 0;
  bit          m_init = 1'b0;

  function automatic logic [31:0] m_fwd(input logic [4:0] rs, input logic [31:0] held);
    if (rs == 0) return held;
    if (mem_rd_we && !mem_is_load && mem_rd_addr == rs) return mem_data;
    if (wb_rd_we && wb_rd_addr == rs) return wb_data;
    return held;
  endfunction

  function automatic bit m_hazard();
    bit h1, h2;
    h1 = !m_h.asel && m_h.rs1 != 0 && mem_rd_addr == m_h.rs1;
    h2 = m_h.rs2 != 0 && mem_rd_addr == m_h.rs2;
    return m_full && mem_rd_we && mem_is_load && (h1 || h2);
  endfunction

  function automatic bit m_valid();
    return m_full && !m_hazard();
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_full  = 1'b0;
      m_h     = '0;
      m_stall = 0;
      m_init  = 1'b1;
    end else begin
      bit v, r;
      v = m_valid();
      r = !m_full || (v && out_ready);
      if (m_hazard() && m_stall < 65535) m_stall++;
      if (flush) m_full = 1'b0;
      else if (in_valid && r) begin m_h = nxt; m_full = 1'b1; end
      else if (v && out_ready) m_full = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      bit v;
      v = m_valid();
      cmp("out_valid", 32'(out_valid), 32'(v));
      cmp("in_ready", 32'(in_ready), 32'(!m_full || (v && out_ready)));
      cmp("A", A, m_h.asel ? m_h.pc : m_fwd(m_h.rs1, m_h.d1));
      cmp("B", B, m_h.bsel ? m_h.imm : m_fwd(m_h.rs2, m_h.d2));
      cmp("out_rs2_fwd", out_rs2_fwd, m_fwd(m_h.rs2, m_h.d2));
      cmp("Ctr", 32'(Ctr), 32'(m_h.ctr));
      cmp("out_pc", out_pc, m_h.pc);
      cmp("out_rd_addr", 32'(out_rd_addr), 32'(m_h.rd));
      cmp("out_rd_we", 32'(out_rd_we), 32'(m_h.we));
      cmp("stall_cnt", 32'(stall_cnt), m_stall);
    end
  end

  // ---------------- directed stimulus ----------------
  function automatic instr_t mk(input logic [31:0] pc, input logic [4:0] rs1,
                                input logic [31:0] d1, input logic [4:0] rs2,
                                input logic [31:0] d2, input logic [31:0] imm,
                                input logic asel, input logic bsel,
                                input logic [3:0] ctr, input logic [4:0] rd);
    instr_t t;
    t.pc = pc; t.rs1 = rs1; t.d1 = d1; t.rs2 = rs2; t.d2 = d2; t.imm = imm;
    t.asel = asel; t.bsel = bsel; t.ctr = ctr; t.rd = rd; t.we = 1'b1;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    nxt = '0; in_valid = 0; flush = 0; out_ready = 1;
    mem_rd_addr = 0; mem_rd_we = 0; mem_is_load = 0; mem_data = 0;
    wb_rd_addr = 0; wb_rd_we = 0; wb_data = 0;
  endtask

  initial begin
    idle();
    rst_n = 0;
    repeat (2) tick();
    rst_n = 1;
    #1;
    cmp("rst out_valid", 32'(out_valid), 0);
    cmp("rst in_ready", 32'(in_ready), 1);
    cmp("rst A", A, 0);
    cmp("rst stall", 32'(stall_cnt), 0);

    // basic flow, back-to-back
    nxt = mk(32'h100, 1, 5, 2, 7, 0, 0, 0, 4'h0, 5); in_valid = 1;
    tick();
    nxt = mk(32'h104, 1, 10, 2, 3, 0, 0, 0, 4'h1, 6);
    #1;
    cmp("basic valid", 32'(out_valid), 1);
    cmp("basic A", A, 5);
    cmp("basic B", B, 7);
    cmp("basic Ctr", 32'(Ctr), 0);
    tick();
    in_valid = 0; #1;
    cmp("b2b A", A, 10);
    cmp("b2b B", B, 3);
    cmp("b2b pc", out_pc, 32'h104);
    tick(); #1;
    cmp("drain valid", 32'(out_valid), 0);

    // forward priority
    nxt = mk(32'h110, 3, 32'h11, 0, 0, 32'h22, 0, 1, 4'h2, 7);
    in_valid = 1; out_ready = 0;
    tick();
    in_valid = 0;
    mem_rd_addr = 3; mem_rd_we = 1; mem_data = 32'hAA;
    wb_rd_addr = 3; wb_rd_we = 1; wb_data = 32'hBB;
    #1;
    cmp("fwd mem A", A, 32'hAA);
    cmp("fwd imm B", B, 32'h22);
    mem_rd_we = 0; #1;
    cmp("fwd wb A", A, 32'hBB);
    wb_rd_we = 0; #1;
    cmp("fwd none A", A, 32'h11);
    tick();
    mem_rd_addr = 0; mem_rd_we = 1; wb_rd_addr = 0; wb_rd_we = 1;
    nxt = mk(32'h114, 0, 0, 0, 0, 0, 0, 0, 4'h3, 0);
    in_valid = 1; out_ready = 1;
    tick();
    in_valid = 0; out_ready = 0; #1;
    cmp("x0 A", A, 0);
    cmp("x0 B", B, 0);
    cmp("x0 pc", out_pc, 32'h114);
    idle();
    tick();

    // load-use on rs2, resolved through WB
    nxt = mk(32'h120, 1, 1, 4, 32'h99, 0, 0, 0, 4'h0, 8); in_valid = 1;
    mem_rd_addr = 4; mem_rd_we = 1; mem_is_load = 1; mem_data = 32'hDEAD;
    tick();
    in_valid = 0; #1;
    cmp("lu valid0", 32'(out_valid), 0);
    tick(); #1;
    cmp("lu valid1", 32'(out_valid), 0);
    cmp("lu stall1", 32'(stall_cnt), 1);
    tick();
    mem_rd_we = 0; mem_is_load = 0;
    wb_rd_addr = 4; wb_rd_we = 1; wb_data = 32'h1234; #1;
    cmp("lu stall2", 32'(stall_cnt), 2);
    cmp("lu valid2", 32'(out_valid), 1);
    cmp("lu B", B, 32'h1234);
    cmp("lu rs2fwd", out_rs2_fwd, 32'h1234);
    tick();
    idle();

    // load to rs1 is harmless when A takes the PC
    nxt = mk(32'h200, 6, 32'h66, 0, 0, 0, 1, 0, 4'h4, 9); in_valid = 1;
    mem_rd_addr = 6; mem_rd_we = 1; mem_is_load = 1;
    tick();
    in_valid = 0; #1;
    cmp("pcsel valid", 32'(out_valid), 1);
    cmp("pcsel A", A, 32'h200);
    tick();
    idle();

    // backpressure
    out_ready = 0;
    nxt = mk(32'h300, 1, 1, 2, 2, 0, 0, 0, 4'h5, 10); in_valid = 1;
    tick();
    nxt = mk(32'h304, 1, 3, 2, 4, 0, 0, 0, 4'h6, 11);
    for (int i = 0; i < 3; i++) begin
      #1;
      cmp("bp in_ready", 32'(in_ready), 0);
      cmp("bp pc", out_pc, 32'h300);
      cmp("bp rd", 32'(out_rd_addr), 10);
      tick();
    end
    out_ready = 1; #1;
    cmp("bp release ready", 32'(in_ready), 1);
    cmp("bp release pc", out_pc, 32'h300);
    tick();
    in_valid = 0; #1;
    cmp("bp next pc", out_pc, 32'h304);
    cmp("bp next Ctr", 32'(Ctr), 6);
    tick(); #1;
    cmp("bp drained", 32'(out_valid), 0);

    // flush with simultaneous accept
    out_ready = 0;
    nxt = mk(32'h400, 1, 1, 2, 2, 0, 0, 0, 4'h7, 12); in_valid = 1;
    tick();
    nxt = mk(32'h404, 1, 1, 2, 2, 0, 0, 0, 4'h8, 13);
    out_ready = 1; flush = 1; #1;
    cmp("flush in_ready", 32'(in_ready), 1);
    tick();
    flush = 0; in_valid = 0; #1;
    cmp("flush valid", 32'(out_valid), 0);
    cmp("flush in_ready2", 32'(in_ready), 1);
    cmp("flush dropped pc", out_pc, 32'h400);

    // saturation of stall counter
    nxt = mk(32'h500, 0, 0, 4, 32'h55, 0, 0, 0, 4'h9, 14); in_valid = 1;
    mem_rd_addr = 4; mem_rd_we = 1; mem_is_load = 1;
    tick();
    in_valid = 0;
    repeat (65540) tick();
    #1;
    cmp("sat stall", 32'(stall_cnt), 32'hFFFF);
    cmp("sat valid", 32'(out_valid), 0);

    // reset while full and stalled
    rst_n = 0;
    tick();
    rst_n = 1;
    idle(); #1;
    cmp("mrst valid", 32'(out_valid), 0);
    cmp("mrst in_ready", 32'(in_ready), 1);
    cmp("mrst A", A, 0);
    cmp("mrst B", B, 0);
    cmp("mrst Ctr", 32'(Ctr), 0);
    cmp("mrst pc", out_pc, 0);
    cmp("mrst rd_we", 32'(out_rd_we), 0);
    cmp("mrst stall", 32'(stall_cnt), 0);
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
